// File: rtl/mem_access_stage_if.sv
// Bundle of the EX-side, WB-side, forwarding and memory-port signals of the memory-access stage.
// The slave modport is the stage itself; the master modport is the surrounding pipeline and memory.
interface mem_access_stage_if #(
  parameter int XLEN  = 64,
  parameter int IDX_W = 61
);
  logic              in_valid;
  logic              in_ready;
  logic [63:0]       in_pc;
  logic [31:0]       in_ins;
  logic              in_mem_ren;
  logic              in_mem_wen;
  logic              in_reg_wen;
  logic [4:0]        in_rdest;
  logic [XLEN-1:0]   in_addr;
  logic [XLEN-1:0]   in_wdata;

  logic              out_valid;
  logic              out_ready;
  logic [63:0]       out_pc;
  logic [31:0]       out_ins;
  logic              out_reg_wen;
  logic [4:0]        out_rdest;
  logic [XLEN-1:0]   out_wb_data;
  logic              out_exc;

  logic              fwd_reg_wen;
  logic [4:0]        fwd_rdest;
  logic [XLEN-1:0]   fwd_data;
  logic              fwd_data_ok;

  logic              mem_req_valid;
  logic              mem_req_ready;
  logic              mem_req_wen;
  logic [IDX_W-1:0]  mem_req_idx;
  logic [XLEN/8-1:0] mem_req_wmask;
  logic [XLEN-1:0]   mem_req_wdata;
  logic              mem_resp_valid;
  logic [XLEN-1:0]   mem_resp_data;

  modport slave (
    input  in_valid, in_pc, in_ins, in_mem_ren, in_mem_wen, in_reg_wen, in_rdest, in_addr, in_wdata,
    output in_ready,
    output out_valid, out_pc, out_ins, out_reg_wen, out_rdest, out_wb_data, out_exc,
    input  out_ready,
    output fwd_reg_wen, fwd_rdest, fwd_data, fwd_data_ok,
    output mem_req_valid, mem_req_wen, mem_req_idx, mem_req_wmask, mem_req_wdata,
    input  mem_req_ready, mem_resp_valid, mem_resp_data
  );

  modport master (
    output in_valid, in_pc, in_ins, in_mem_ren, in_mem_wen, in_reg_wen, in_rdest, in_addr, in_wdata,
    input  in_ready,
    input  out_valid, out_pc, out_ins, out_reg_wen, out_rdest, out_wb_data, out_exc,
    output out_ready,
    input  fwd_reg_wen, fwd_rdest, fwd_data, fwd_data_ok,
    input  mem_req_valid, mem_req_wen, mem_req_idx, mem_req_wmask, mem_req_wdata,
    output mem_req_ready, mem_resp_valid, mem_resp_data
  );
endinterface

// File: rtl/mem_access_stage.sv
// Pipeline memory-access stage: one EX instruction at a time, load/store over a stallable
// valid/ready memory port, registered result to WB, plus same-stage forwarding info.
module mem_access_stage #(
  parameter int          XLEN     = 64,
  parameter logic [63:0] MEM_BASE = 64'h8000_0000,
  parameter int          IDX_W    = 61
) (
  input logic               clk,
  input logic               reset,
  mem_access_stage_if.slave bus
);
  localparam int STRB_W = XLEN / 8;
  localparam int OFF_W  = $clog2(STRB_W);

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  state_t            state;
  logic              ready_int;
  logic              accept;

  logic [2:0]        funct3;
  logic [1:0]        size;
  logic              is_mem;
  logic              is_store;
  logic              misaligned;
  logic              illegal;
  logic              exc;
  logic [OFF_W-1:0]  off;
  logic [XLEN-1:0]   rel_addr;
  logic [IDX_W-1:0]  req_idx;
  logic [STRB_W-1:0] mask_base;
  logic [XLEN-1:0]   repl_wdata;

  logic [63:0]       lat_pc;
  logic [31:0]       lat_ins;
  logic              lat_reg_wen;
  logic [4:0]        lat_rdest;
  logic [2:0]        lat_funct3;
  logic [OFF_W-1:0]  lat_off;
  logic              lat_store;

  logic [XLEN-1:0]   shifted;
  logic [XLEN-1:0]   load_data;

  assign ready_int    = (state == IDLE) && (!bus.out_valid || bus.out_ready);
  assign bus.in_ready = ready_int;
  assign accept       = bus.in_valid && ready_int;

  assign funct3   = bus.in_ins[14:12];
  assign size     = funct3[1:0];
  assign is_store = bus.in_mem_wen;
  assign is_mem   = bus.in_mem_ren || bus.in_mem_wen;
  assign off      = bus.in_addr[OFF_W-1:0];
  assign rel_addr = bus.in_addr - XLEN'(MEM_BASE);
  assign req_idx  = IDX_W'(rel_addr >> OFF_W);

  // NOTE: every variable written in always_comb gets a default first, so no path infers a latch.
  always_comb begin
    misaligned = 1'b0;
    case (size)
      2'd1:    misaligned = bus.in_addr[0];
      2'd2:    misaligned = (bus.in_addr[1:0] != 2'b00);
      2'd3:    misaligned = (bus.in_addr[2:0] != 3'b000);
      default: misaligned = 1'b0;
    endcase

    // Stores only define sb/sh/sw/sd; loads leave funct3=7 undefined.
    illegal = is_store ? funct3[2] : (funct3 == 3'd7);
    if ((XLEN == 32) && ((size == 2'd3) || (!is_store && funct3 == 3'd6)))
      illegal = 1'b1;

    exc = is_mem && (misaligned || illegal);

    mask_base  = '1;
    repl_wdata = bus.in_wdata;
    case (size)
      2'd0: begin
        mask_base  = STRB_W'(1);
        repl_wdata = {STRB_W{bus.in_wdata[7:0]}};
      end
      2'd1: begin
        mask_base  = STRB_W'(3);
        repl_wdata = {(XLEN/16){bus.in_wdata[15:0]}};
      end
      2'd2: begin
        mask_base  = STRB_W'(15);
        repl_wdata = {(XLEN/32){bus.in_wdata[31:0]}};
      end
      default: begin
        mask_base  = '1;
        repl_wdata = bus.in_wdata;
      end
    endcase
  end

  // Response is only ever consumed into a register, never onto an output directly.
  always_comb begin
    shifted   = bus.mem_resp_data >> {lat_off, 3'b000};
    load_data = '0;
    case (lat_funct3)
      3'd0:    load_data = XLEN'($signed(shifted[7:0]));
      3'd1:    load_data = XLEN'($signed(shifted[15:0]));
      3'd2:    load_data = XLEN'($signed(shifted[31:0]));
      3'd3:    load_data = shifted;
      3'd4:    load_data = XLEN'(shifted[7:0]);
      3'd5:    load_data = XLEN'(shifted[15:0]);
      3'd6:    load_data = XLEN'(shifted[31:0]);
      default: load_data = '0;
    endcase
  end

  // NOTE: reset is synchronous here, and all state uses non-blocking assignments so every
  // register samples its pre-edge inputs regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state             <= IDLE;
      bus.out_valid     <= 1'b0;
      bus.out_pc        <= '0;
      bus.out_ins       <= '0;
      bus.out_reg_wen   <= 1'b0;
      bus.out_rdest     <= '0;
      bus.out_wb_data   <= '0;
      bus.out_exc       <= 1'b0;
      bus.mem_req_valid <= 1'b0;
      bus.mem_req_wen   <= 1'b0;
      bus.mem_req_idx   <= '0;
      bus.mem_req_wmask <= '0;
      bus.mem_req_wdata <= '0;
      lat_pc            <= '0;
      lat_ins           <= '0;
      lat_reg_wen       <= 1'b0;
      lat_rdest         <= '0;
      lat_funct3        <= '0;
      lat_off           <= '0;
      lat_store         <= 1'b0;
    end else begin
      if (bus.out_valid && bus.out_ready)
        bus.out_valid <= 1'b0;

      case (state)
        IDLE: begin
          if (accept) begin
            if (!is_mem || exc) begin
              bus.out_valid   <= 1'b1;
              bus.out_pc      <= bus.in_pc;
              bus.out_ins     <= bus.in_ins;
              bus.out_reg_wen <= bus.in_reg_wen && !exc;
              bus.out_rdest   <= bus.in_rdest;
              bus.out_wb_data <= bus.in_addr;
              bus.out_exc     <= exc;
            end else begin
              lat_pc            <= bus.in_pc;
              lat_ins           <= bus.in_ins;
              lat_reg_wen       <= bus.in_reg_wen && !is_store;
              lat_rdest         <= bus.in_rdest;
              lat_funct3        <= funct3;
              lat_off           <= off;
              lat_store         <= is_store;
              bus.mem_req_valid <= 1'b1;
              bus.mem_req_wen   <= is_store;
              bus.mem_req_idx   <= req_idx;
              bus.mem_req_wmask <= is_store ? (mask_base << off) : '0;
              bus.mem_req_wdata <= is_store ? repl_wdata : '0;
              state             <= REQ;
            end
          end
        end
        REQ: begin
          if (bus.mem_req_ready) begin
            bus.mem_req_valid <= 1'b0;
            state             <= WAIT;
          end
        end
        WAIT: begin
          if (bus.mem_resp_valid) begin
            bus.out_valid   <= 1'b1;
            bus.out_pc      <= lat_pc;
            bus.out_ins     <= lat_ins;
            bus.out_reg_wen <= lat_reg_wen;
            bus.out_rdest   <= lat_rdest;
            bus.out_wb_data <= lat_store ? '0 : load_data;
            bus.out_exc     <= 1'b0;
            state           <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // While a memory op is in flight the latched copy is authoritative; afterwards the output regs.
  always_comb begin
    bus.fwd_reg_wen = 1'b0;
    bus.fwd_rdest   = '0;
    bus.fwd_data    = '0;
    bus.fwd_data_ok = 1'b0;
    if (state != IDLE) begin
      bus.fwd_reg_wen = lat_reg_wen;
      bus.fwd_rdest   = lat_rdest;
      bus.fwd_data    = '0;
      bus.fwd_data_ok = lat_store;
    end else if (bus.out_valid) begin
      bus.fwd_reg_wen = bus.out_reg_wen;
      bus.fwd_rdest   = bus.out_rdest;
      bus.fwd_data    = bus.out_wb_data;
      bus.fwd_data_ok = 1'b1;
    end
  end
endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: ALU pass-through, loads, stores, misalignment,
// backpressure on both handshakes, and reset during an outstanding access.
module tb_mem_access_stage;
  logic clk;
  logic reset;
  int   n_cmp = 0;
  int   n_err = 0;

  mem_access_stage_if #(.XLEN(64), .IDX_W(61)) bus ();

  mem_access_stage #(.XLEN(64), .MEM_BASE(64'h8000_0000), .IDX_W(61)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mk_ins(input logic [2:0] f3, input logic [6:0] opc);
    return {17'b0, f3, 5'b0, opc};
  endfunction

  task automatic drive(input logic [2:0] f3, input logic ren, input logic wen, input logic rwen,
                       input logic [4:0] rd, input logic [63:0] addr, input logic [63:0] wdata);
    bus.in_valid   = 1'b1;
    bus.in_pc      = 64'h1000 + {56'b0, rd, 3'b0};
    bus.in_ins     = mk_ins(f3, wen ? 7'h23 : (ren ? 7'h03 : 7'h13));
    bus.in_mem_ren = ren;
    bus.in_mem_wen = wen;
    bus.in_reg_wen = rwen;
    bus.in_rdest   = rd;
    bus.in_addr    = addr;
    bus.in_wdata   = wdata;
  endtask

  // Zero-wait memory op: accept, request, response, result, then drain.
  task automatic mem_op(input string tag, input logic [2:0] f3, input logic st,
                        input logic [63:0] addr, input logic [63:0] wdata, input logic [63:0] resp,
                        input logic [63:0] exp_idx, input logic [7:0] exp_mask,
                        input logic [63:0] exp_wdata, input logic [63:0] exp_wb);
    drive(f3, !st, st, !st, 5'd7, addr, wdata);
    check({tag, "_in_ready"}, 64'(bus.in_ready), 64'd1);
    step();
    bus.in_valid = 1'b0;
    check({tag, "_req_valid"}, 64'(bus.mem_req_valid), 64'd1);
    check({tag, "_req_idx"}, 64'(bus.mem_req_idx), exp_idx);
    check({tag, "_req_wen"}, 64'(bus.mem_req_wen), 64'(st));
    check({tag, "_fwd_ok_req"}, 64'(bus.fwd_data_ok), 64'(st));
    if (st) begin
      check({tag, "_wmask"}, 64'(bus.mem_req_wmask), 64'(exp_mask));
      check({tag, "_wdata"}, bus.mem_req_wdata, exp_wdata);
    end
    step();
    check({tag, "_req_dropped"}, 64'(bus.mem_req_valid), 64'd0);
    bus.mem_resp_valid = 1'b1;
    bus.mem_resp_data  = resp;
    step();
    bus.mem_resp_valid = 1'b0;
    check({tag, "_out_valid"}, 64'(bus.out_valid), 64'd1);
    check({tag, "_wb_data"}, bus.out_wb_data, exp_wb);
    check({tag, "_reg_wen"}, 64'(bus.out_reg_wen), 64'(!st));
    check({tag, "_exc"}, 64'(bus.out_exc), 64'd0);
    step();
    check({tag, "_drained"}, 64'(bus.out_valid), 64'd0);
  endtask

  initial begin
    reset              = 1'b1;
    bus.in_valid       = 1'b0;
    bus.in_pc          = '0;
    bus.in_ins         = '0;
    bus.in_mem_ren     = 1'b0;
    bus.in_mem_wen     = 1'b0;
    bus.in_reg_wen     = 1'b0;
    bus.in_rdest       = '0;
    bus.in_addr        = '0;
    bus.in_wdata       = '0;
    bus.out_ready      = 1'b1;
    bus.mem_req_ready  = 1'b1;
    bus.mem_resp_valid = 1'b0;
    bus.mem_resp_data  = '0;
    step();
    step();

    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_req_valid", 64'(bus.mem_req_valid), 64'd0);
    check("rst_exc", 64'(bus.out_exc), 64'd0);
    check("rst_fwd_wen", 64'(bus.fwd_reg_wen), 64'd0);
    check("rst_fwd_ok", 64'(bus.fwd_data_ok), 64'd0);
    check("rst_wb_data", bus.out_wb_data, 64'd0);
    check("rst_req_idx", 64'(bus.mem_req_idx), 64'd0);
    check("rst_in_ready", 64'(bus.in_ready), 64'd1);
    reset = 1'b0;
    step();

    // ALU pass-through
    drive(3'd0, 1'b0, 1'b0, 1'b1, 5'd5, 64'h1234, 64'h0);
    step();
    bus.in_valid = 1'b0;
    check("alu_out_valid", 64'(bus.out_valid), 64'd1);
    check("alu_wb_data", bus.out_wb_data, 64'h1234);
    check("alu_rdest", 64'(bus.out_rdest), 64'd5);
    check("alu_reg_wen", 64'(bus.out_reg_wen), 64'd1);
    check("alu_no_req", 64'(bus.mem_req_valid), 64'd0);
    check("alu_fwd_data", bus.fwd_data, 64'h1234);
    check("alu_fwd_ok", 64'(bus.fwd_data_ok), 64'd1);
    step();
    check("alu_drained", 64'(bus.out_valid), 64'd0);

    mem_op("lb",  3'd0, 1'b0, 64'h8000_0003, 64'h0, 64'h0000_0000_8000_0000,
           64'd0, 8'h00, 64'h0, 64'hFFFF_FFFF_FFFF_FF80);
    mem_op("lbu", 3'd4, 1'b0, 64'h8000_0003, 64'h0, 64'h0000_0000_8000_0000,
           64'd0, 8'h00, 64'h0, 64'h0000_0000_0000_0080);
    mem_op("lw",  3'd2, 1'b0, 64'h8000_0004, 64'h0, 64'h8765_4321_0000_0000,
           64'd0, 8'h00, 64'h0, 64'hFFFF_FFFF_8765_4321);
    mem_op("lh",  3'd1, 1'b0, 64'h8000_000E, 64'h0, 64'h8001_0000_0000_0000,
           64'd1, 8'h00, 64'h0, 64'hFFFF_FFFF_FFFF_8001);
    mem_op("sh",  3'd1, 1'b1, 64'h8000_000A, 64'hABCD, 64'hDEAD_BEEF_DEAD_BEEF,
           64'd1, 8'h0C, 64'hABCD_ABCD_ABCD_ABCD, 64'h0);
    mem_op("sw",  3'd2, 1'b1, 64'h8000_0014, 64'h1122_3344_5566_7788, 64'h0,
           64'd2, 8'hF0, 64'h5566_7788_5566_7788, 64'h0);

    // Misaligned word load: exception, no memory request
    drive(3'd2, 1'b1, 1'b0, 1'b1, 5'd9, 64'h8000_0002, 64'h0);
    step();
    bus.in_valid = 1'b0;
    check("mis_lw_valid", 64'(bus.out_valid), 64'd1);
    check("mis_lw_exc", 64'(bus.out_exc), 64'd1);
    check("mis_lw_reg_wen", 64'(bus.out_reg_wen), 64'd0);
    check("mis_lw_wb", bus.out_wb_data, 64'h8000_0002);
    check("mis_lw_no_req", 64'(bus.mem_req_valid), 64'd0);
    step();
    check("mis_lw_no_req2", 64'(bus.mem_req_valid), 64'd0);

    // Misaligned doubleword store at a word-aligned address
    drive(3'd3, 1'b0, 1'b1, 1'b0, 5'd0, 64'h8000_0004, 64'h55);
    step();
    bus.in_valid = 1'b0;
    check("mis_sd_exc", 64'(bus.out_exc), 64'd1);
    check("mis_sd_no_req", 64'(bus.mem_req_valid), 64'd0);
    step();

    // Backpressure on request then on WB
    bus.mem_req_ready = 1'b0;
    drive(3'd2, 1'b1, 1'b0, 1'b1, 5'd11, 64'h8000_0010, 64'h0);
    step();
    bus.in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("bp_req_valid", 64'(bus.mem_req_valid), 64'd1);
      check("bp_req_idx", 64'(bus.mem_req_idx), 64'd2);
      check("bp_in_ready", 64'(bus.in_ready), 64'd0);
      check("bp_fwd_ok", 64'(bus.fwd_data_ok), 64'd0);
      check("bp_fwd_rd", 64'(bus.fwd_rdest), 64'd11);
      step();
    end
    check("bp_req_hold", 64'(bus.mem_req_valid), 64'd1);
    bus.mem_req_ready = 1'b1;
    step();
    bus.mem_req_ready = 1'b0;
    check("bp_wait_fwd_ok", 64'(bus.fwd_data_ok), 64'd0);
    check("bp_wait_in_ready", 64'(bus.in_ready), 64'd0);
    bus.out_ready      = 1'b0;
    bus.mem_resp_valid = 1'b1;
    bus.mem_resp_data  = 64'h0000_0000_1234_5678;
    step();
    bus.mem_resp_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      check("bp_out_valid", 64'(bus.out_valid), 64'd1);
      check("bp_wb", bus.out_wb_data, 64'h0000_0000_1234_5678);
      check("bp_fwd_ok_rsp", 64'(bus.fwd_data_ok), 64'd1);
      check("bp_fwd_data", bus.fwd_data, 64'h0000_0000_1234_5678);
      check("bp_out_in_ready", 64'(bus.in_ready), 64'd0);
      step();
    end
    bus.out_ready = 1'b1;
    #1;
    check("bp_release_in_ready", 64'(bus.in_ready), 64'd1);
    step();
    check("bp_single_xfer", 64'(bus.out_valid), 64'd0);
    bus.mem_req_ready = 1'b1;

    // Reset while waiting for the response
    drive(3'd2, 1'b1, 1'b0, 1'b1, 5'd13, 64'h8000_0018, 64'h0);
    step();
    bus.in_valid = 1'b0;
    step();
    check("rw_in_wait", 64'(bus.in_ready), 64'd0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("rw_out_valid", 64'(bus.out_valid), 64'd0);
    check("rw_req_valid", 64'(bus.mem_req_valid), 64'd0);
    check("rw_idle", 64'(bus.in_ready), 64'd1);
    bus.mem_resp_valid = 1'b1;
    bus.mem_resp_data  = 64'hFFFF_FFFF_FFFF_FFFF;
    step();
    bus.mem_resp_valid = 1'b0;
    check("rw_late_resp", 64'(bus.out_valid), 64'd0);
    step();
    check("rw_late_resp2", 64'(bus.out_valid), 64'd0);
    check("rw_fwd_ok", 64'(bus.fwd_data_ok), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
